// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_pkg
// Desc    : Shared opcodes, FSM states and step-mode constants for the MDU.
// Rev     : 1.0  initial release
// ============================================================================
package mdu_pkg;

   localparam int MDU_OP_W = 3;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_MULT  = 3'b000,
      MDU_MULTU = 3'b001,
      MDU_DIV   = 3'b010,
      MDU_DIVU  = 3'b011,
      MDU_MTHI  = 3'b100,
      MDU_MTLO  = 3'b101
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module  : mdu_if
// Desc    : Request/result bundle between the EX stage and the MDU.
// Rev     : 1.0  initial release
// ============================================================================
interface mdu_if import mdu_pkg::*; #(parameter int WIDTH = 32) ();

   logic                start;
   logic [MDU_OP_W-1:0] op;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic                flush;
   logic                busy;
   logic                done;
   logic                dz;
   logic [WIDTH-1:0]    hi;
   logic [WIDTH-1:0]    lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, dz, hi, lo
   );

endinterface
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module  : mdu_step
// Desc    : One shift-add (mult) or restoring-subtract (div) iteration.
//           Divider half present only when MDU_DIV_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module mdu_step import mdu_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_part,
   input  logic [WIDTH-1:0] i_opnd,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_part_nxt,
   output logic             o_bit
);

   logic [WIDTH:0] w_sum;
`ifdef MDU_DIV_EN
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;
`endif

   always_comb begin
      // mult: i_bit is the multiplier LSB, o_bit drops into the low product half
      w_sum      = {1'b0, i_part} + (i_bit ? {1'b0, i_opnd} : '0);
      o_part_nxt = w_sum[WIDTH:1];
      o_bit      = w_sum[0];
`ifdef MDU_DIV_EN
      w_shift    = {i_part, i_bit};
      w_diff     = w_shift - {1'b0, i_opnd};
`endif
      if (i_mode == MODE_DIV) begin
`ifdef MDU_DIV_EN
         // borrow out of the top bit means the divisor did not fit
         if (!w_diff[WIDTH]) begin
            o_part_nxt = w_diff[WIDTH-1:0];
            o_bit      = 1'b1;
         end else begin
            o_part_nxt = w_shift[WIDTH-1:0];
            o_bit      = 1'b0;
         end
`else
         o_part_nxt = i_part;
         o_bit      = 1'b0;
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module  : mdu_seq
// Desc    : Iterative one-bit-per-cycle multiply/divide unit with HI/LO.
//           Define MDU_DIV_EN to include DIV/DIVU; otherwise they are no-ops.
// Rev     : 1.0  initial release
// ============================================================================
module mdu_seq import mdu_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic reset_n,
   mdu_if.slave bus
);

   localparam int               CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

   mdu_state_e         r_state;
   mdu_state_e         w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_part;
   logic [WIDTH-1:0]   r_shreg;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_neg_res;
   logic               r_done;

   logic               w_accept;
   logic               w_wr_hi;
   logic               w_wr_lo;
   logic               w_step;
   logic               w_fix;
   logic               w_mode;
   logic               w_in_bit;
   logic               w_out_bit;
   logic [WIDTH-1:0]   w_part_nxt;
   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

`ifdef MDU_DIV_EN
   logic               r_is_div;
   logic               r_neg_rem;
   logic               r_bzero;
   logic               r_dz;
   logic               w_is_div_op;

   assign w_is_div_op = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
   assign w_mode      = r_is_div;
   assign bus.dz      = r_dz;
`else
   assign w_mode      = MODE_MUL;
   assign bus.dz      = 1'b0;
`endif

   assign w_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
   assign w_a_neg  = w_signed & bus.a[WIDTH-1];
   assign w_b_neg  = w_signed & bus.b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
   assign w_b_mag  = w_b_neg ? -bus.b : bus.b;
   assign w_in_bit = (w_mode == MODE_DIV) ? r_shreg[WIDTH-1] : r_shreg[0];

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_mode     (w_mode),
      .i_part     (r_part),
      .i_opnd     (r_opnd),
      .i_bit      (w_in_bit),
      .o_part_nxt (w_part_nxt),
      .o_bit      (w_out_bit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_wr_hi     = 1'b0;
      w_wr_lo     = 1'b0;
      w_step      = 1'b0;
      w_fix       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // flush blocks every kind of acceptance on the same edge
            if (bus.start && !bus.flush) begin
               case (bus.op)
                  MDU_MULT, MDU_MULTU: begin
                     w_accept    = 1'b1;
                     w_state_nxt = ST_RUN;
                  end
                  MDU_DIV, MDU_DIVU: begin
`ifdef MDU_DIV_EN
                     w_accept    = 1'b1;
                     w_state_nxt = ST_RUN;
`endif
                  end
                  MDU_MTHI: w_wr_hi = 1'b1;
                  MDU_MTLO: w_wr_lo = 1'b1;
                  default:  ;
               endcase
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_step = 1'b1;
               if (r_cnt == C_CNT_LAST) w_state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            w_state_nxt = ST_IDLE;
            w_fix       = !bus.flush;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_prod   = r_neg_res ? -{r_part, r_shreg} : {r_part, r_shreg};
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
      // on /0 the remainder walks the whole dividend, so re-signing it restores a
      if (r_is_div) begin
         w_res_hi = r_neg_rem ? -r_part : r_part;
         w_res_lo = r_bzero ? '1 : (r_neg_res ? -r_shreg : r_shreg);
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_part    <= '0;
         r_shreg   <= '0;
         r_opnd    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_neg_res <= 1'b0;
         r_done    <= 1'b0;
`ifdef MDU_DIV_EN
         r_is_div  <= 1'b0;
         r_neg_rem <= 1'b0;
         r_bzero   <= 1'b0;
         r_dz      <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_cnt     <= C_CNT_INIT;
            r_part    <= '0;
            r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef MDU_DIV_EN
            r_dz      <= 1'b0;
            r_is_div  <= w_is_div_op;
            r_neg_rem <= w_a_neg;
            r_bzero   <= (bus.b == '0);
            r_shreg   <= w_is_div_op ? w_a_mag : w_b_mag;
            r_opnd    <= w_is_div_op ? w_b_mag : w_a_mag;
`else
            r_shreg   <= w_b_mag;
            r_opnd    <= w_a_mag;
`endif
         end else if (w_step) begin
            r_cnt   <= r_cnt - C_CNT_LAST;
            r_part  <= w_part_nxt;
            r_shreg <= (w_mode == MODE_DIV) ? {r_shreg[WIDTH-2:0], w_out_bit}
                                            : {w_out_bit, r_shreg[WIDTH-1:1]};
         end
         if (w_wr_hi) r_hi <= bus.a;
         if (w_wr_lo) r_lo <= bus.a;
         if (w_fix) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
`ifdef MDU_DIV_EN
            r_dz   <= r_is_div & r_bzero;
`endif
         end
      end
   end

   assign bus.busy = (r_state != ST_IDLE);
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the sequential successor to the single-cycle ALU multiply path. It sits beside the ALU in EX and handles MULT/MULTU/DIV/DIVU/MTHI/MTLO. Operations run one bit per cycle; the pipeline stalls on busy and reads HI/LO directly.

Parameters:
WIDTH, 32, operand/HI/LO width (>=4, even)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; accepted when start && !busy
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
a  in  WIDTH  operand a / dividend / MTHI-MTLO data
b  in  WIDTH  operand b / divisor
flush  in  1  synchronous abort of the in-flight op
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO just updated by mult/div
dz  out  1  sticky-until-next-accept divide-by-zero flag
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, dz=0, hi=0, lo=0, counter=0. Reset mid-operation discards all work.
- FSM states: IDLE -> RUN -> FIX -> IDLE.
- Acceptance at edge E0 (start && !busy && op is MULT/MULTU/DIV/DIVU):
  - Latch operands. Signed ops store |a| and |b| plus result-sign bits.
  - busy=1, dz=0, state=RUN, counter=WIDTH.
- RUN: one shift-add (mult) or restoring-subtract (div) step per edge. Counter decrements. At counter 1 -> FIX. RUN covers edges E1..E_WIDTH.
- FIX (edge E_WIDTH+1):
  - Apply sign correction and write HI/LO.
  - done=1 for exactly that cycle; busy=0; state IDLE.
  - Total latency: result visible WIDTH+1 edges after accept.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, two's complement for MULT.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1: lo=MIN, hi=0, no flag.
- Divide by zero: hi=a (original), lo=all ones, no sign fix, dz=1 from FIX edge until next accept. Full latency is still taken.
- MTHI/MTLO while !busy: write hi/lo at E0, single cycle, busy stays 0, done stays 0.
- Reserved op: ignored.
- start while busy: ignored entirely (no queueing); the requester must hold start until !busy.
- flush=1 on any edge in RUN/FIX: return to IDLE, busy=0, no done, HI/LO unchanged.
- flush has priority over start on the same edge; nothing is accepted.
- Same-edge done and new start: busy is still 1 at the FIX edge, so the start is not taken. Earliest back-to-back accept is the edge after done.

Optional Feature:
MDU_DIV_EN. Defined: DIV/DIVU as above. Undefined: divider datapath is removed. DIV/DIVU are accepted as single-cycle no-ops: busy stays 0, hi/lo unchanged, no done. dz is tied 0.

Decomposition:
- Package mdu_pkg: op enum (MDU_MULT..MDU_MTLO), FSM state enum, opcode width constant.
- One sub-module mdu_step: combinational single iteration. Inputs are partial remainder/product, operand, and mode. Outputs are the next partial value and a quotient bit.
- FSM, counter, sign fix, HI/LO and flags stay in mdu_seq.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at 33rd edge after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-7 b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=2111222333 b=2 -> hi=0, lo=4222444666. MULT a=-1 b=-1 -> hi=0, lo=1.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 -> hi=7, lo=0xFFFFFFFF, dz=1, cleared on next accept. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9 while idle -> hi/lo updated on the accept edge, busy never asserted. MTLO issued while busy -> ignored.
- Flush at edge 10 of a MULT after hi/lo hold known values -> busy drops next edge, no done, hi/lo unchanged. Restart accepted the next cycle and completes normally.
- reset_n pulsed low mid-DIV (asynchronously, between edges) -> all outputs 0 immediately. Repeat the directed cases with WIDTH=8 (e.g. MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, 9-edge latency), built with and without MDU_DIV_EN.
